// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, default wait count and FSM state encoding for mem_responder
package mem_pkg;
  localparam int MEM_AW = 8;
  localparam int MEM_DW = 16;
  localparam int MEM_WAIT_CYCLES = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: word storage with sync write and registered read; even parity per word under MEM_RESPONDER_PARITY_EN
module mem_array import mem_pkg::*; #(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          perr
);
`ifdef MEM_RESPONDER_PARITY_EN
  logic [DW:0] mem [2**AW];
  always_ff @(posedge clk)
    if (en && we) mem[addr] <= {^wdata, wdata};
  always_ff @(posedge clk)
    if (rst) begin
      rdata <= '0;
      perr  <= 1'b0;
    end else if (en && !we) begin
      rdata <= mem[addr][DW-1:0];
      perr  <= ^mem[addr];
    end
`else
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  assign perr = 1'b0;
`endif
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with fixed wait latency; parity via MEM_RESPONDER_PARITY_EN
module mem_responder import mem_pkg::*; #(
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES,
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          perr
);
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_r, go, op_we, perr_r;
  logic [AW-1:0] addr_r, op_addr;
  logic [DW-1:0] wdata_r, op_wdata;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == WAIT && state_n == WAIT) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && req) begin
        we_r    <= we;
        addr_r  <= addr;
        wdata_r <= wdata;
      end
    end
  always_comb begin
    state_n = state == IDLE ? (req ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (cnt + 4'd1 == 4'(WAIT_CYCLES) ? RESP : WAIT) : IDLE;
    // With zero wait the commit edge is the capture edge, so use the live inputs then
    go       = !rst && state_n == RESP && state != RESP;
    op_we    = state == IDLE ? we : we_r;
    op_addr  = state == IDLE ? addr : addr_r;
    op_wdata = state == IDLE ? wdata : wdata_r;
  end
  mem_array #(.AW(AW), .DW(DW)) u_mem (
    .clk(clk), .rst(rst), .en(go), .we(op_we), .addr(op_addr),
    .wdata(op_wdata), .rdata(rdata), .perr(perr_r)
  );
  assign ack  = state == RESP;
  assign busy = state != IDLE;
  assign perr = ack && perr_r;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized directed bench against an array-based reference model
module tb_mem_responder;
`ifdef MEM_RESPONDER_PARITY_EN
  localparam int MW = 17;
`else
  localparam int MW = 16;
`endif
  logic clk = 0, rst, req, req0, we;
  logic [7:0] addr;
  logic [15:0] wdata, rdata, rdata0;
  logic ack, busy, perr, ack0, busy0, perr0;
  logic [15:0] model_mem [256];
  logic [15:0] model_rd;
  int checks = 0, failures = 0;

  mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .perr(perr)
  );
  mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack0), .rdata(rdata0), .busy(busy0), .perr(perr0)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] enc(input logic [15:0] d);
`ifdef MEM_RESPONDER_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; latency is counted, not assumed
  task automatic txn(input logic w, input logic [7:0] a, input logic [15:0] d, input logic ep);
    int n;
    logic [15:0] exp_rd;
    @(negedge clk);
    req = 1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 0; we = 1'($urandom); addr = 8'($urandom); wdata = 16'($urandom);
    exp_rd = w ? model_rd : model_mem[a];
    if (w) model_mem[a] = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (ack) break;
      n++;
      if (n > 20) begin
        chk("ack_timeout", 0, 1);
        return;
      end
    end
    chk("latency", n, 2);
    chk("busy_in_ack", busy, 1);
    chk("rdata", rdata, exp_rd);
    chk("perr", perr, ep);
    model_rd = exp_rd;
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int acks;
    rst = 1; req = 0; req0 = 0; we = 0; addr = 0; wdata = 0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 16'($urandom);
      dut.u_mem.mem[i] = enc(model_mem[i]);
    end
    model_mem[8'h0D] = 16'h1234;
    dut.u_mem.mem[8'h0D] = enc(16'h1234);
    dut0.u_mem.mem[0] = enc(16'hA5C3);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", perr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy0", busy0, 0);
    model_rd = 0;
    rst = 0;

    txn(0, 8'h0D, 0, 0);
    txn(1, 8'hFF, 16'hBEEF, 0);
    txn(0, 8'hFF, 0, 0);
    for (int i = 0; i < 24; i++)
      txn(1'($urandom), 8'h40 + 8'($urandom_range(0, 7)), 16'($urandom), 0);

    // req held for 10 edges: captures at 1,5,9 -> acks after edges 3 and 7
    @(negedge clk);
    req = 1; we = 0; addr = 8'h30;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    req = 0;
    chk("held_acks", acks, 2);
    chk("held_busy", busy, 1);
    for (int i = 0; i < 20 && !ack; i++) @(negedge clk);
    chk("held_third_ack", ack, 1);
    chk("held_rdata", rdata, model_mem[8'h30]);
    model_rd = model_mem[8'h30];
    @(negedge clk);

    // reset while a write sits in WAIT
    @(negedge clk);
    req = 1; we = 1; addr = 8'h10; wdata = 16'h5555;
    @(posedge clk);
    #1;
    req = 0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_perr", perr, 0);
    chk("mid_rst_rdata", rdata, 0);
    model_rd = 0;
    rst = 0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("mid_no_ack", acks, 0);
    chk("mid_mem_kept", dut.u_mem.mem[8'h10][15:0], model_mem[8'h10]);
    txn(0, 8'h10, 0, 0);

    // zero-wait instance
    @(negedge clk);
    req0 = 1; we = 0; addr = 8'h00;
    @(posedge clk);
    #1;
    req0 = 0;
    chk("w0_ack", ack0, 1);
    chk("w0_busy", busy0, 1);
    chk("w0_rdata", rdata0, 16'hA5C3);
    @(posedge clk);
    #1;
    chk("w0_ack_drop", ack0, 0);
    chk("w0_busy_drop", busy0, 0);

`ifdef MEM_RESPONDER_PARITY_EN
    dut.u_mem.mem[8'h20][3] = ~dut.u_mem.mem[8'h20][3];
    model_mem[8'h20] = model_mem[8'h20] ^ 16'h0008;
    txn(0, 8'h20, 0, 1);
    txn(0, 8'h21, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
